dekatron_counter_ctrl: RTL and testbench
========================================

// Module: dekatron_counter_ctrl
// PURPOSE
//  Sequencer for a chain of DIGITS Dekatron digit cells that together form one multi-digit decimal register.
//  Takes increment, decrement and load requests on a ready/request handshake.
//  Issues edge-timed Step pulses with Reverse/Set qualifiers, and ripples carry/borrow one digit at a time.
//  Checks that each stepped digit still reads as a valid one-hot value. Sits between the DPC control unit and the digit cells.
// PARAMETERS
//  DIGITS        3  number of digit cells, digit 0 = least significant
//  STEP_CYCLES   2  clock cycles DekStep is held high (min 1)
//  SETTLE_CYCLES 3  clock cycles waited after Step falls before DekOut is sampled (min 1)
// PORTS
//  Clk        in   1          single clock, all state on posedge
//  Rst        in   1          asynchronous, active-high reset
//  Request    in   1          operation request, sampled only when Ready=1
//  Dec        in   1          0 = +1, 1 = -1 (ignored when Set=1)
//  Set        in   1          load SetValue into all digits
//  SetValue   in   DIGITS*10  one-hot per digit, digit i at [10*i+9:10*i]
//  Ready      out  1          idle, request will be accepted
//  Done       out  1          one-cycle pulse, operation finished
//  Overflow   out  1          carry/borrow left the top digit (999+1 or 000-1)
//  Error      out  1          sticky: sampled digit not exactly one-hot
//  Zero       out  1          combinational: every digit reads 10'b1
//  DekRst_n   out  1          active-low reset to all digit cells
//  DekStep    out  DIGITS     per-digit Step strobes
//  DekReverse out  1          Reverse to all digits
//  DekSet     out  1          Set to all digits
//  DekIn      out  DIGITS*10  load value to digits
//  DekOut     in   DIGITS*10  digit cell outputs
// BEHAVIOUR
//  Reset values: Ready=0, Done=0, Overflow=0, Error=0, DekRst_n=0, DekStep=0, DekReverse=0, DekSet=0, DekIn=0, state IDLE, digit index=0.
//  Rst released: on the first Clk edge, DekRst_n goes 1 and Ready goes 1.
//  FSM IDLE->SETUP->PULSE->SETTLE->CHECK->(PULSE | IDLE).
//  IDLE: Ready=1. Request=1 is accepted on a clock edge; Ready drops, Overflow clears, index=0.
//    DekIn<=SetValue; DekSet<=Set; DekReverse<=Dec & ~Set. Set has priority over Dec.
//  SETUP (1 cycle): qualifiers are stable before any Step rising edge. DekStep stays 0.
//  PULSE (STEP_CYCLES cycles): inc/dec drives only DekStep[index]=1; load drives DekStep all-ones.
//  SETTLE (SETTLE_CYCLES cycles): DekStep=0.
//  CHECK (1 cycle): sample DekOut.
//    Any checked digit not one-hot sets Error, then go IDLE with Done.
//    Load checks all digits. Inc/dec checks the digit at index.
//    Carry on inc: digit now 10'b1 (wrapped 9->0). Borrow on dec: digit now bit 9 (wrapped 0->9).
//    Carry/borrow and index<DIGITS-1: index++, go to PULSE (no SETUP; qualifiers unchanged).
//    Carry/borrow at top digit: Overflow=1, go IDLE.
//    Otherwise go IDLE.
//  Return to IDLE: Done=1 and Ready=1 in the same cycle. DekSet, DekReverse and DekIn are held until the next accept.
//  Latency, accept edge to Done edge: 1 + k*(STEP_CYCLES+SETTLE_CYCLES+1), k = digits stepped (1 for load).
//  Request while Ready=0 is ignored, not queued. Error stays set until Rst; later requests still run.
//  Rst mid-operation drops DekStep to 0 and DekRst_n to 0 asynchronously; the partial ripple is abandoned.
//  Counters are sized by $clog2 of max(STEP_CYCLES, SETTLE_CYCLES) and $clog2(DIGITS).
// STRUCTURE
//  dekatron_pkg: state encoding localparams, DEK_W=10, DEK_ZERO=10'b0000000001, DEK_NINE=10'b1000000000.
//  Sub-module dekatron_digit_check: 10-bit in -> is_onehot, is_zero, is_nine (combinational). One instance per digit; also feeds Zero.
// TESTING (DIGITS=3, STEP_CYCLES=2, SETTLE_CYCLES=3, behavioural Dekatron models on DekOut)
//  Reset, inc on 000 -> DekStep[0] high 2 cycles, value 001, Done 7 edges after accept, Overflow=0.
//  Preload 099, inc -> DekStep[0], [1], [2] pulsed in order, value 100, Done at 19 edges.
//  Preload 000, dec -> DekReverse=1 throughout, value 999, Overflow=1, Done at 19 edges.
//  Load 507 with Set=1 and Dec=1 -> DekSet=1, DekReverse=0, all DekStep high together, Done at 7, Zero=0.
//  DekOut digit 0 forced to 10'b0000000011 during CHECK -> Error=1, Done, Ready=1, no further DekStep.
//  Rst pulsed during PULSE -> DekStep=0 and DekRst_n=0 immediately; Ready=1 one edge after release; Request during busy is ignored.

Source files
------------

// File: rtl/dekatron_counter_ctrl_pkg.sv
// Shared constants and FSM encoding for the Dekatron counter sequencer.
package dekatron_counter_ctrl_pkg;

   localparam int DEK_W = 10;
   localparam logic [DEK_W-1:0] DEK_ZERO = 10'b0000000001;
   localparam logic [DEK_W-1:0] DEK_NINE = 10'b1000000000;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETUP  = 3'd1,
      ST_PULSE  = 3'd2,
      ST_SETTLE = 3'd3,
      ST_CHECK  = 3'd4
   } state_t;

endpackage

// File: rtl/dekatron_counter_ctrl_if.sv
// Request/status bundle between the DPC control unit (master) and the sequencer (slave).
interface dekatron_counter_ctrl_if
   import dekatron_counter_ctrl_pkg::*;
#(
   parameter int DIGITS = 3
) ();

   logic                    request;
   logic                    dec;
   logic                    set;
   logic [DIGITS*DEK_W-1:0] set_value;
   logic                    ready;
   logic                    done;
   logic                    overflow;
   logic                    error;
   logic                    zero;

   modport master (
      output request, dec, set, set_value,
      input  ready, done, overflow, error, zero
   );

   modport slave (
      input  request, dec, set, set_value,
      output ready, done, overflow, error, zero
   );

endinterface

// File: rtl/dekatron_counter_ctrl_digit_check.sv
// Decodes one Dekatron cell output: valid one-hot, reads 0, reads 9.
module dekatron_counter_ctrl_digit_check
   import dekatron_counter_ctrl_pkg::*;
(
   input  logic [DEK_W-1:0] digit,
   output logic             is_onehot,
   output logic             is_zero,
   output logic             is_nine
);

   assign is_onehot = (digit != '0) && ((digit & (digit - DEK_W'(1))) == '0);
   assign is_zero   = (digit == DEK_ZERO);
   assign is_nine   = (digit == DEK_NINE);

endmodule

// File: rtl/dekatron_counter_ctrl.sv
// Sequencer for a chain of Dekatron digit cells: step/load timing, carry/borrow ripple, one-hot checking.
//
// state     | meaning
// ----------|-----------------------------------------------------------
// ST_IDLE   | ready for a request; qualifiers and load value held
// ST_SETUP  | qualifiers settle one cycle ahead of the first Step edge
// ST_PULSE  | Step high for STEP_CYCLES (one digit, or all on load)
// ST_SETTLE | Step low for SETTLE_CYCLES before the cell is sampled
// ST_CHECK  | sample DekOut, flag error, ripple or finish
module dekatron_counter_ctrl
   import dekatron_counter_ctrl_pkg::*;
#(
   parameter int DIGITS        = 3,
   parameter int STEP_CYCLES   = 2,
   parameter int SETTLE_CYCLES = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   dekatron_counter_ctrl_if.slave  bus,
   output logic                    dek_rst_n,
   output logic [DIGITS-1:0]       dek_step,
   output logic                    dek_reverse,
   output logic                    dek_set,
   output logic [DIGITS*DEK_W-1:0] dek_in,
   input  logic [DIGITS*DEK_W-1:0] dek_out
);

   localparam int MAX_CYCLES = (STEP_CYCLES > SETTLE_CYCLES) ? STEP_CYCLES : SETTLE_CYCLES;
   localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
   localparam int IW         = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [CW-1:0] STEP_LOAD   = CW'(STEP_CYCLES - 1);
   localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
   localparam logic [IW-1:0] TOP_IDX     = IW'(DIGITS - 1);

   state_t                  state, state_d;
   logic [CW-1:0]           cnt, cnt_d;
   logic [IW-1:0]           idx, idx_d;
   logic                    set_d, rev_d;
   logic [DIGITS*DEK_W-1:0] in_d;
   logic                    overflow, overflow_d;
   logic                    error, error_d;
   logic                    done, done_d;
   logic [DIGITS-1:0]       step_d;

   logic [DIGITS-1:0]       onehot, zero, nine, sel;
   logic                    bad, wrap;

   for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      dekatron_counter_ctrl_digit_check u_check (
         .digit     (dek_out[g*DEK_W +: DEK_W]),
         .is_onehot (onehot[g]),
         .is_zero   (zero[g]),
         .is_nine   (nine[g])
      );
      assign sel[g] = (idx == IW'(g));
   end

   // A load verifies every cell; inc/dec only the cell just stepped.
   assign bad  = dek_set ? ~(&onehot) : |(sel & ~onehot);
   assign wrap = |(sel & (dek_reverse ? nine : zero));

   assign bus.ready    = dek_rst_n && (state == ST_IDLE);
   assign bus.done     = done;
   assign bus.overflow = overflow;
   assign bus.error    = error;
   assign bus.zero     = &zero;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         idx         <= '0;
         dek_rst_n   <= 1'b0;
         dek_step    <= '0;
         dek_reverse <= 1'b0;
         dek_set     <= 1'b0;
         dek_in      <= '0;
         overflow    <= 1'b0;
         error       <= 1'b0;
         done        <= 1'b0;
      end else begin
         state       <= state_d;
         cnt         <= cnt_d;
         idx         <= idx_d;
         dek_rst_n   <= 1'b1;
         dek_step    <= step_d;
         dek_reverse <= rev_d;
         dek_set     <= set_d;
         dek_in      <= in_d;
         overflow    <= overflow_d;
         error       <= error_d;
         done        <= done_d;
      end
   end

   always_comb begin
      state_d    = state;
      cnt_d      = cnt;
      idx_d      = idx;
      set_d      = dek_set;
      rev_d      = dek_reverse;
      in_d       = dek_in;
      overflow_d = overflow;
      error_d    = error;
      done_d     = 1'b0;
      step_d     = '0;

      unique case (state)
         ST_IDLE: begin
            if (dek_rst_n && bus.request) begin
               state_d    = ST_SETUP;
               overflow_d = 1'b0;
               idx_d      = '0;
               in_d       = bus.set_value;
               set_d      = bus.set;
               rev_d      = bus.dec & ~bus.set;
            end
         end
         ST_SETUP: begin
            state_d = ST_PULSE;
            cnt_d   = STEP_LOAD;
         end
         ST_PULSE: begin
            if (cnt == '0) begin
               state_d = ST_SETTLE;
               cnt_d   = SETTLE_LOAD;
            end else begin
               cnt_d = cnt - 1'b1;
            end
         end
         ST_SETTLE: begin
            if (cnt == '0) begin
               state_d = ST_CHECK;
            end else begin
               cnt_d = cnt - 1'b1;
            end
         end
         ST_CHECK: begin
            if (bad) begin
               error_d = 1'b1;
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end else if (!dek_set && wrap && (idx != TOP_IDX)) begin
               // Ripple straight into the next cell; qualifiers are already stable.
               idx_d   = idx + 1'b1;
               state_d = ST_PULSE;
               cnt_d   = STEP_LOAD;
            end else begin
               overflow_d = !dek_set && wrap;
               state_d    = ST_IDLE;
               done_d     = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      for (int i = 0; i < DIGITS; i++) begin
         step_d[i] = (state_d == ST_PULSE) && (set_d || (idx_d == IW'(i)));
      end
   end

endmodule

// File: tb/tb_dekatron_counter_ctrl.sv
// Self-checking bench: behavioural Dekatron cells on dek_out plus a decimal reference model.
module tb_dekatron_counter_ctrl;

   localparam int DIGITS        = 3;
   localparam int STEP_CYCLES   = 2;
   localparam int SETTLE_CYCLES = 3;
   localparam int OP_CYCLES     = STEP_CYCLES + SETTLE_CYCLES + 1;
   localparam int MODULUS       = 1000;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   dek_rst_n;
   logic [DIGITS-1:0]      dek_step;
   logic                   dek_reverse;
   logic                   dek_set;
   logic [DIGITS*10-1:0]   dek_in;
   logic [DIGITS*10-1:0]   dek_out;

   dekatron_counter_ctrl_if #(.DIGITS(DIGITS)) bus ();

   dekatron_counter_ctrl #(
      .DIGITS        (DIGITS),
      .STEP_CYCLES   (STEP_CYCLES),
      .SETTLE_CYCLES (SETTLE_CYCLES)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .dek_rst_n   (dek_rst_n),
      .dek_step    (dek_step),
      .dek_reverse (dek_reverse),
      .dek_set     (dek_set),
      .dek_in      (dek_in),
      .dek_out     (dek_out)
   );

   always #5 clk = ~clk;

   int                checks   = 0;
   int                failures = 0;
   int                cur;
   bit                exp_err;
   logic              force_bad;
   logic              exp_rev, exp_set;

   int                dv [DIGITS];
   logic [DIGITS-1:0] prev_step;
   int                pulse_len;
   int                qual_bad = 0;
   int                pat_q [$];
   int                len_q [$];

   task automatic check_val(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   function automatic int oh_to_int(input logic [9:0] x);
      for (int j = 0; j < 10; j++) if (x[j]) return j;
      return 0;
   endfunction

   function automatic int digit_of(input int v, input int i);
      int r = v;
      for (int j = 0; j < i; j++) r = r / 10;
      return r % 10;
   endfunction

   function automatic logic [DIGITS*10-1:0] enc(input int v);
      logic [DIGITS*10-1:0] r = '0;
      for (int i = 0; i < DIGITS; i++) r[10*i + digit_of(v, i)] = 1'b1;
      return r;
   endfunction

   function automatic int model_value();
      return dv[2] * 100 + dv[1] * 10 + dv[0];
   endfunction

   // Behavioural Dekatron cells: advance on each rising Step edge.
   always_comb begin
      dek_out = '0;
      for (int i = 0; i < DIGITS; i++) dek_out[10*i +: 10] = 10'(1) << dv[i];
      if (force_bad) dek_out[9:0] = 10'b0000000011;
   end

   always @(negedge clk or negedge dek_rst_n) begin
      if (!dek_rst_n) begin
         for (int i = 0; i < DIGITS; i++) dv[i] <= 0;
         prev_step <= '0;
         pulse_len <= 0;
      end else begin
         for (int i = 0; i < DIGITS; i++) begin
            if (dek_step[i] && !prev_step[i])
               dv[i] <= dek_set ? oh_to_int(dek_in[10*i +: 10]) :
                        dek_reverse ? (dv[i] + 9) % 10 : (dv[i] + 1) % 10;
         end
         if (dek_step != '0 && prev_step == '0) begin
            pat_q.push_back(int'(dek_step));
            pulse_len <= 1;
         end else if (dek_step != '0) begin
            pulse_len <= pulse_len + 1;
         end else if (prev_step != '0) begin
            len_q.push_back(pulse_len);
         end
         if (!bus.ready && (dek_reverse !== exp_rev || dek_set !== exp_set))
            qual_bad <= qual_bad + 1;
         prev_step <= dek_step;
      end
   end

   task automatic wait_ready();
      int n = 0;
      while (!bus.ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check_val("ready_before_req", 32'(bus.ready), 1);
   endtask

   task automatic run_op(input bit dec_i, input bit set_i, input int load_v, input bit inject);
      int k, exp_val, exp_lat, n, base_p, base_l, qb0, mism;
      bit exp_ovf, seen;
      wait_ready();
      if (set_i) begin
         k = 1; exp_val = load_v; exp_ovf = 1'b0;
      end else if (force_bad) begin
         k = 1; exp_ovf = 1'b0;
         exp_val = cur - cur % 10 + (cur % 10 + (dec_i ? 9 : 1)) % 10;
      end else if (!dec_i) begin
         k = 1;
         for (int i = 0; i < DIGITS - 1 && digit_of(cur, i) == 9; i++) k++;
         exp_val = (cur + 1) % MODULUS;
         exp_ovf = (cur == MODULUS - 1);
      end else begin
         k = 1;
         for (int i = 0; i < DIGITS - 1 && digit_of(cur, i) == 0; i++) k++;
         exp_val = (cur + MODULUS - 1) % MODULUS;
         exp_ovf = (cur == 0);
      end
      exp_lat = 1 + k * OP_CYCLES;
      base_p  = pat_q.size();
      base_l  = len_q.size();
      qb0     = qual_bad;

      @(negedge clk);
      bus.request   = 1'b1;
      bus.dec       = dec_i;
      bus.set       = set_i;
      bus.set_value = enc(load_v);
      exp_set       = set_i;
      exp_rev       = dec_i & ~set_i;
      @(posedge clk); #1;
      bus.request   = 1'b0;
      bus.dec       = 1'($urandom_range(0, 1));
      bus.set_value = 30'($urandom);
      check_val("busy_after_accept", 32'(bus.ready), 0);

      n = 0; seen = 1'b0;
      while (!seen && n < 200) begin
         @(posedge clk); #1;
         n++;
         if (inject && n == 2) begin
            bus.request = 1'b1;
            bus.dec     = ~dec_i;
            bus.set     = 1'($urandom_range(0, 1));
         end
         if (inject && n == 3) bus.request = 1'b0;
         seen = bus.done;
      end
      bus.set = 1'b0;
      check_val("done_seen", 32'(seen), 1);
      check_val("latency", n, exp_lat);
      check_val("ready_with_done", 32'(bus.ready), 1);
      cur = exp_val;
      check_val("value", model_value(), exp_val);
      check_val("overflow", 32'(bus.overflow), 32'(exp_ovf));
      check_val("error", 32'(bus.error), 32'(exp_err));
      check_val("zero", 32'(bus.zero), 32'(exp_val == 0 && !force_bad));
      check_val("pulse_count", pat_q.size() - base_p, k);
      mism = 0;
      for (int j = 0; j < k && base_p + j < pat_q.size(); j++)
         if (pat_q[base_p + j] != (set_i ? (1 << DIGITS) - 1 : (1 << j))) mism++;
      for (int j = base_l; j < len_q.size(); j++)
         if (len_q[j] != STEP_CYCLES) mism++;
      check_val("pulse_shape", mism, 0);
      check_val("qualifier_glitches", qual_bad - qb0, 0);
      if (set_i) check_val("dek_in_held", 32'(dek_in == enc(load_v)), 1);
      @(posedge clk); #1;
      check_val("done_one_cycle", 32'(bus.done), 0);
      check_val("qualifiers_held", 32'({dek_set, dek_reverse}), 32'({exp_set, exp_rev}));
   endtask

   task automatic reset_mid_pulse();
      wait_ready();
      @(negedge clk);
      bus.request = 1'b1; bus.dec = 1'b0; bus.set = 1'b0;
      exp_set = 1'b0; exp_rev = 1'b0;
      @(posedge clk); #1;
      bus.request = 1'b0;
      @(posedge clk); #1;
      check_val("step_in_pulse", 32'(dek_step), 1);
      rst = 1'b1;
      #1;
      check_val("rst_step_low", 32'(dek_step), 0);
      check_val("rst_dek_rst_n", 32'(dek_rst_n), 0);
      check_val("rst_ready_low", 32'(bus.ready), 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_val("ready_before_first_edge", 32'(bus.ready), 0);
      @(posedge clk); #1;
      check_val("ready_after_release", 32'(bus.ready), 1);
      check_val("dek_rst_n_after_release", 32'(dek_rst_n), 1);
      check_val("error_cleared", 32'(bus.error), 0);
      cur = 0;
      exp_err = 1'b0;
      check_val("value_after_rst", model_value(), 0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog expired got=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int v, kind, base;
      bus.request = 1'b0; bus.dec = 1'b0; bus.set = 1'b0; bus.set_value = '0;
      force_bad = 1'b0; exp_rev = 1'b0; exp_set = 1'b0;
      cur = 0; exp_err = 1'b0;
      rst = 1'b0;
      #1 rst = 1'b1;
      #12;
      check_val("rst_ready", 32'(bus.ready), 0);
      check_val("rst_done", 32'(bus.done), 0);
      check_val("rst_overflow", 32'(bus.overflow), 0);
      check_val("rst_error", 32'(bus.error), 0);
      check_val("rst_dek_rst_n", 32'(dek_rst_n), 0);
      check_val("rst_outputs", 32'({dek_step, dek_reverse, dek_set}), 0);
      check_val("rst_dek_in", 32'(dek_in), 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_val("ready_held_after_release", 32'(bus.ready), 0);
      @(posedge clk); #1;
      check_val("ready_first_edge", 32'(bus.ready), 1);
      check_val("dek_rst_n_first_edge", 32'(dek_rst_n), 1);

      run_op(1'b0, 1'b0, 0, 1'b0);       // 000 + 1
      run_op(1'b0, 1'b1, 99, 1'b0);      // load 099
      run_op(1'b0, 1'b0, 0, 1'b1);       // 099 + 1, full ripple
      run_op(1'b0, 1'b1, 0, 1'b0);       // load 000
      run_op(1'b1, 1'b0, 0, 1'b0);       // 000 - 1, borrow out
      run_op(1'b1, 1'b1, 507, 1'b0);     // load beats dec
      run_op(1'b0, 1'b0, 0, 1'b0);

      force_bad = 1'b1;
      exp_err   = 1'b1;
      run_op(1'b0, 1'b0, 0, 1'b0);
      base = pat_q.size();
      repeat (5) @(posedge clk);
      #1;
      check_val("no_step_after_error", pat_q.size() - base, 0);
      force_bad = 1'b0;
      run_op(1'b1, 1'b0, 0, 1'b0);       // error is sticky, ops still run

      reset_mid_pulse();

      for (int t = 0; t < 30; t++) begin
         kind = int'($urandom_range(0, 9));
         if (kind < 3) begin
            case ($urandom_range(0, 3))
               0:       v = 999;
               1:       v = 0;
               2:       v = int'($urandom_range(0, 9)) * 100 + ($urandom_range(0, 1) != 0 ? 99 : 0);
               default: v = int'($urandom_range(0, 999));
            endcase
            run_op(1'($urandom_range(0, 1)), 1'b1, v, 1'($urandom_range(0, 1)));
         end else begin
            run_op(kind >= 7, 1'b0, 0, 1'($urandom_range(0, 1)));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
